// File: rtl/div_stall_unit_if.sv
// ============================================================================
// Module      : div_stall_unit_if
// Description : EX-stage divide request/result bundle between pipeline and
//               the multi-cycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_stall_unit_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              EX_DivSel;
  logic [5:0]        EX_func;
  logic [DATA_W-1:0] EX_dataA;
  logic [DATA_W-1:0] EX_dataB;
  logic              div_stall;
  logic              div_busy;
  logic              div_done;
  logic              div_by_zero;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  modport master (
    output flush, EX_DivSel, EX_func, EX_dataA, EX_dataB,
    input  div_stall, div_busy, div_done, div_by_zero, div_quotient, div_remainder
  );

  modport slave (
    input  flush, EX_DivSel, EX_func, EX_dataA, EX_dataB,
    output div_stall, div_busy, div_done, div_by_zero, div_quotient, div_remainder
  );
endinterface

`default_nettype wire

// File: rtl/div_stall_unit.sv
// ============================================================================
// Module      : div_stall_unit
// Description : Radix-2 restoring DIV/DIVU unit with pipeline stall, 34-cycle
//               latency for nonzero divisors, 1 cycle for divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_stall_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  wire logic         cpu_clk,
  input  wire logic         reset,
  div_stall_unit_if.slave   bus
);

  localparam int         CNT_W      = $clog2(ITER);
  localparam logic [5:0] c_func_div  = 6'b011010;
  localparam logic [5:0] c_func_divu = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [DATA_W-1:0] qout_q, qout_d;
  logic [DATA_W-1:0] rout_q, rout_d;
  logic              dbz_q, dbz_d;

  logic              w_is_div;
  logic              w_is_signed;
  logic              w_start;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [DATA_W:0]   w_rem_sh;
  logic              w_fits;
  logic [DATA_W-1:0] w_diff;

  assign w_is_div    = (bus.EX_func == c_func_div) || (bus.EX_func == c_func_divu);
  assign w_is_signed = (bus.EX_func == c_func_div);
  assign w_start     = (state_q == S_IDLE) && bus.EX_DivSel && w_is_div && !bus.flush;

  assign w_sign_a = w_is_signed && bus.EX_dataA[DATA_W-1];
  assign w_sign_b = w_is_signed && bus.EX_dataB[DATA_W-1];
  assign w_abs_a  = w_sign_a ? (~bus.EX_dataA + 1'b1) : bus.EX_dataA;
  assign w_abs_b  = w_sign_b ? (~bus.EX_dataB + 1'b1) : bus.EX_dataB;

  // Shifted partial remainder needs one extra bit; the difference fits in
  // DATA_W bits whenever the trial subtraction succeeds.
  assign w_rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, dvs_q});
  assign w_diff   = w_rem_sh[DATA_W-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          if (bus.EX_dataB == '0) begin
            qout_d  = '1;
            rout_d  = bus.EX_dataA;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = w_abs_a;
            dvs_d   = w_abs_b;
            negq_d  = w_sign_a ^ w_sign_b;
            negr_d  = w_sign_a;
            cnt_d   = CNT_W'(ITER - 1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_fits ? w_diff : w_rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], w_fits};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIXUP;
          end
        end
      end
      S_FIXUP: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          qout_d  = negq_q ? (~quo_q + 1'b1) : quo_q;
          rout_d  = negr_q ? (~rem_q + 1'b1) : rem_q;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.div_stall     = !bus.flush &&
                             (w_start || (state_q == S_CALC) || (state_q == S_FIXUP));
  assign bus.div_busy      = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.div_done      = (state_q == S_DONE);
  assign bus.div_by_zero   = dbz_q;
  assign bus.div_quotient  = qout_q;
  assign bus.div_remainder = rout_q;

endmodule

`default_nettype wire

// File: tb/tb_div_stall_unit.sv
// ============================================================================
// Module      : tb_div_stall_unit
// Description : Self-checking bench for div_stall_unit against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_stall_unit;

  localparam logic [5:0] c_div  = 6'b011010;
  localparam logic [5:0] c_divu = 6'b011011;

  logic cpu_clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 cpu_clk = ~cpu_clk;

  div_stall_unit_if #(.DATA_W(32)) dif ();

  div_stall_unit #(.DATA_W(32), .ITER(32)) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (dif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa;
    int sb;
    sa = a;
    sb = b;
    z  = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (f == c_divu) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Issue one divide, then scramble operands while it runs; checks latency,
  // stall length, results and single-cycle done pulse.
  task automatic do_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          elat, stall_cnt, done_cyc;
    ref_div(f, a, b, eq, er, ez);
    elat      = ez ? 1 : 34;
    stall_cnt = 0;
    done_cyc  = -1;
    @(negedge cpu_clk);
    dif.EX_DivSel = 1'b1;
    dif.EX_func   = f;
    dif.EX_dataA  = a;
    dif.EX_dataB  = b;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (dif.div_stall) stall_cnt++;
      if (dif.div_done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge cpu_clk);
      #1;
      dif.EX_DivSel = 1'b0;
      dif.EX_dataA  = $urandom;
      dif.EX_dataB  = $urandom;
      @(negedge cpu_clk);
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("latency", 32'(done_cyc), 32'(elat));
    chk("stall_cycles", 32'(stall_cnt), 32'(elat));
    chk("quotient", dif.div_quotient, eq);
    chk("remainder", dif.div_remainder, er);
    chk("by_zero", 32'(dif.div_by_zero), 32'(ez));
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    #1;
    chk("done_pulse", 32'(dif.div_done), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, hq, hr;
    logic [5:0]  f;
    int          seen, done_cyc;

    reset         = 1'b0;
    dif.flush     = 1'b0;
    dif.EX_DivSel = 1'b0;
    dif.EX_func   = 6'd0;
    dif.EX_dataA  = 32'd0;
    dif.EX_dataB  = 32'd0;
    #12;
    chk("rst_quotient", dif.div_quotient, 32'd0);
    chk("rst_remainder", dif.div_remainder, 32'd0);
    chk("rst_done", 32'(dif.div_done), 32'd0);
    chk("rst_busy", 32'(dif.div_busy), 32'd0);
    chk("rst_stall", 32'(dif.div_stall), 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge cpu_clk);
    reset = 1'b1;

    do_div(c_divu, 32'd100, 32'd7);
    do_div(c_div, 32'hFFFF_FFF9, 32'd2);
    do_div(c_div, 32'd7, 32'hFFFF_FFFE);
    do_div(c_div, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(c_divu, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(c_divu, 32'd5, 32'd0);
    do_div(c_div, 32'hFFFF_FFF0, 32'd0);

    // Non-divide function code must not start anything.
    @(negedge cpu_clk);
    dif.EX_DivSel = 1'b1;
    dif.EX_func   = 6'b011000;
    #1;
    chk("nondiv_stall", 32'(dif.div_stall), 32'd0);
    @(posedge cpu_clk);
    #1;
    chk("nondiv_busy", 32'(dif.div_busy), 32'd0);
    dif.EX_DivSel = 1'b0;

    for (int i = 0; i < 40; i++) begin
      f = ($urandom_range(0, 1) == 0) ? c_div : c_divu;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_div(f, a, b);
    end

    // Flush mid-CALC after a known 100/7.
    do_div(c_divu, 32'd100, 32'd7);
    @(negedge cpu_clk);
    dif.EX_DivSel = 1'b1;
    dif.EX_func   = c_divu;
    dif.EX_dataA  = 32'd50;
    dif.EX_dataB  = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(posedge cpu_clk);
      #1;
      dif.EX_DivSel = 1'b0;
      @(negedge cpu_clk);
    end
    dif.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(dif.div_stall), 32'd0);
    chk("flush_busy_before", 32'(dif.div_busy), 32'd1);
    @(posedge cpu_clk);
    #1;
    dif.flush = 1'b0;
    chk("flush_busy_after", 32'(dif.div_busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge cpu_clk);
      #1;
      if (dif.div_done) seen = 1;
    end
    chk("flush_nodone", 32'(seen), 32'd0);
    chk("flush_quotient", dif.div_quotient, 32'd14);
    chk("flush_remainder", dif.div_remainder, 32'd2);

    // Asynchronous reset mid-CALC.
    @(negedge cpu_clk);
    dif.EX_DivSel = 1'b1;
    dif.EX_func   = c_divu;
    dif.EX_dataA  = 32'd123456;
    dif.EX_dataB  = 32'd789;
    @(posedge cpu_clk);
    #1;
    dif.EX_DivSel = 1'b0;
    repeat (5) @(posedge cpu_clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_quotient", dif.div_quotient, 32'd0);
    chk("arst_remainder", dif.div_remainder, 32'd0);
    chk("arst_busy", 32'(dif.div_busy), 32'd0);
    chk("arst_stall", 32'(dif.div_stall), 32'd0);
    @(negedge cpu_clk);
    reset = 1'b1;

    // EX_DivSel held across DONE: restart only in the following IDLE cycle.
    @(negedge cpu_clk);
    dif.EX_DivSel = 1'b1;
    dif.EX_func   = c_divu;
    dif.EX_dataA  = 32'd1000;
    dif.EX_dataB  = 32'd10;
    done_cyc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (dif.div_done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge cpu_clk);
    end
    chk("held_latency", 32'(done_cyc), 32'd34);
    chk("held_done_stall", 32'(dif.div_stall), 32'd0);
    chk("held_quotient", dif.div_quotient, 32'd100);
    @(negedge cpu_clk);
    #1;
    chk("held_restart_stall", 32'(dif.div_stall), 32'd1);
    chk("held_restart_busy", 32'(dif.div_busy), 32'd0);
    @(posedge cpu_clk);
    #1;
    dif.EX_DivSel = 1'b0;
    ref_div(c_divu, 32'd1000, 32'd10, hq, hr, seen[0]);
    seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge cpu_clk);
      #1;
      if (dif.div_done) begin
        seen = 1;
        break;
      end
    end
    chk("held_second_done", 32'(seen), 32'd1);
    chk("held_second_quotient", dif.div_quotient, hq);
    chk("held_second_remainder", dif.div_remainder, hr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
